game_sprite_motion: RTL and testbench

- Sprite-side responder to the game master FSM's sprite control strobes: write_xy, write_dxy, enable_update.
- Holds sprite position and velocity, and steps position by velocity at a fixed cycle period while updates are enabled.
- Reports sprite_within_screen back to the master.
- One instance per sprite (target, torpedo); outputs feed the display and collision logic.

---
 rtl/game_sprite_motion_pkg.sv | 29 ++
 rtl/game_sprite_tick_divider.sv | 48 ++++
 rtl/game_sprite_motion.sv | 170 +++++++++++++++++
 tb/tb_game_sprite_motion.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sprite_motion_pkg.sv
// -----------------------------------------------------------------------------
// game_sprite_motion_pkg
// Shared game configuration for the sprite motion responders: position and
// velocity widths, screen and sprite box sizes, the motion step period and the
// sprite state encoding.
//
// Optional feature macro: GAME_SPRITE_BOUNCE_EN. It is left undefined by
// default, so sprites leaving the screen horizontally freeze in the OUT state.
// Define it at build time to make the sprite reflect off the left/right edges.
// -----------------------------------------------------------------------------
package game_sprite_motion_pkg;

  localparam int GSM_X_WIDTH        = 10;
  localparam int GSM_Y_WIDTH        = 10;
  localparam int GSM_DXY_WIDTH      = 4;
  localparam int GSM_SCREEN_WIDTH   = 640;
  localparam int GSM_SCREEN_HEIGHT  = 480;
  localparam int GSM_SPRITE_WIDTH   = 8;
  localparam int GSM_SPRITE_HEIGHT  = 8;
  localparam int GSM_UPDATE_PERIOD  = 4;

  // Sprite motion states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_OUT    = 2'd2
  } sprite_state_e;

endpackage : game_sprite_motion_pkg

// File: rtl/game_sprite_tick_divider.sv
// -----------------------------------------------------------------------------
// game_sprite_tick_divider
// Free-running modulo-PERIOD counter with enable and synchronous clear. Emits a
// one-cycle tick in the cycle the count sits at PERIOD-1 while enabled, so the
// first tick after leaving a cleared state comes PERIOD enabled cycles later.
//
// Ports:
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   i_en    in  count enable
//   i_clr   in  synchronous clear (wins over i_en)
//   o_tick  out tick, high in the last cycle of each period while enabled
// -----------------------------------------------------------------------------
module game_sprite_tick_divider #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;

  // Period counter: clear has priority, wraps after the last count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_count == L_LAST) begin
        r_count <= {CW{1'b0}};
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tick = i_en && (r_count == L_LAST);

endmodule : game_sprite_tick_divider

// File: rtl/game_sprite_motion.sv
// -----------------------------------------------------------------------------
// game_sprite_motion
// Sprite-side responder to the game master's sprite control strobes. Holds the
// sprite position and velocity, steps position by velocity once per
// UPDATE_PERIOD cycles while updates are enabled, and reports whether the
// sprite box is fully on screen. One instance per sprite.
//
// Optional feature macro: GAME_SPRITE_BOUNCE_EN (undefined by default).
// When defined, a step that leaves the screen only in x clamps x to the edge
// and negates dx instead of freezing the sprite.
//
// Ports:
//   clk                   in  clock
//   reset                 in  asynchronous active-high reset
//   sprite_write_xy       in  load position strobe
//   sprite_write_x/y      in  position to load
//   sprite_write_dxy      in  load velocity strobe
//   sprite_write_dx/dy    in  signed velocity to load
//   sprite_enable_update  in  motion runs while high
//   sprite_x/y            out current position
//   sprite_within_screen  out sprite box fully on screen (sticky low in OUT)
// -----------------------------------------------------------------------------
module game_sprite_motion
  import game_sprite_motion_pkg::*;
#(
  parameter int X_WIDTH       = GSM_X_WIDTH,
  parameter int Y_WIDTH       = GSM_Y_WIDTH,
  parameter int DXY_WIDTH     = GSM_DXY_WIDTH,
  parameter int SCREEN_WIDTH  = GSM_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = GSM_SCREEN_HEIGHT,
  parameter int SPRITE_WIDTH  = GSM_SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = GSM_SPRITE_HEIGHT,
  parameter int UPDATE_PERIOD = GSM_UPDATE_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sprite_write_xy,
  input  logic [X_WIDTH-1:0]   sprite_write_x,
  input  logic [Y_WIDTH-1:0]   sprite_write_y,
  input  logic                 sprite_write_dxy,
  input  logic [DXY_WIDTH-1:0] sprite_write_dx,
  input  logic [DXY_WIDTH-1:0] sprite_write_dy,
  input  logic                 sprite_enable_update,
  output logic [X_WIDTH-1:0]   sprite_x,
  output logic [Y_WIDTH-1:0]   sprite_y,
  output logic                 sprite_within_screen
);

  localparam logic [X_WIDTH-1:0] L_MAX_X = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
  localparam logic [Y_WIDTH-1:0] L_MAX_Y = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

  sprite_state_e          r_state;
  logic [X_WIDTH-1:0]     r_x;
  logic [Y_WIDTH-1:0]     r_y;
  logic [DXY_WIDTH-1:0]   r_dx;
  logic [DXY_WIDTH-1:0]   r_dy;
  logic                   r_within;

  logic                   w_tick;
  logic                   w_cnt_en;
  logic                   w_cnt_clr;
  logic [X_WIDTH:0]       w_dx_ext;
  logic [Y_WIDTH:0]       w_dy_ext;
  logic [X_WIDTH:0]       w_nx;
  logic [Y_WIDTH:0]       w_ny;
  logic                   w_x_oob;
  logic                   w_y_oob;
  logic                   w_load_ok;

  // The counter only runs while motion is enabled and the sprite is not frozen;
  // a position load restarts the period.
  assign w_cnt_en  = sprite_enable_update && (r_state != ST_OUT);
  assign w_cnt_clr = sprite_write_xy || !sprite_enable_update;

  game_sprite_tick_divider #(
    .PERIOD (UPDATE_PERIOD)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_cnt_en),
    .i_clr  (w_cnt_clr),
    .o_tick (w_tick)
  );

  // One extra bit on the candidate position: its MSB flags a step below zero,
  // since an in-range position plus a small velocity never reaches 2^WIDTH.
  assign w_dx_ext = {{(X_WIDTH + 1 - DXY_WIDTH){r_dx[DXY_WIDTH-1]}}, r_dx};
  assign w_dy_ext = {{(Y_WIDTH + 1 - DXY_WIDTH){r_dy[DXY_WIDTH-1]}}, r_dy};
  assign w_nx     = {1'b0, r_x} + w_dx_ext;
  assign w_ny     = {1'b0, r_y} + w_dy_ext;
  assign w_x_oob  = w_nx[X_WIDTH] || (w_nx[X_WIDTH-1:0] > L_MAX_X);
  assign w_y_oob  = w_ny[Y_WIDTH] || (w_ny[Y_WIDTH-1:0] > L_MAX_Y);
  assign w_load_ok = (sprite_write_x <= L_MAX_X) && (sprite_write_y <= L_MAX_Y);

  // Sprite state machine with position, velocity and on-screen flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_x      <= {X_WIDTH{1'b0}};
      r_y      <= {Y_WIDTH{1'b0}};
      r_dx     <= {DXY_WIDTH{1'b0}};
      r_dy     <= {DXY_WIDTH{1'b0}};
      r_within <= 1'b1;
    end else begin
      // Velocity load; a tick in this cycle still steps with the old value
      if (sprite_write_dxy) begin
        r_dx <= sprite_write_dx;
        r_dy <= sprite_write_dy;
      end

      if (sprite_write_xy) begin
        // A position load overrides any step due this cycle
        r_x      <= sprite_write_x;
        r_y      <= sprite_write_y;
        r_within <= w_load_ok;
        if (!w_load_ok) begin
          r_state <= ST_OUT;
        end else if (sprite_enable_update) begin
          r_state <= ST_MOVING;
        end else begin
          r_state <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (sprite_enable_update) begin
              r_state <= ST_MOVING;
            end
          end
          ST_MOVING: begin
            if (!sprite_enable_update) begin
              r_state <= ST_IDLE;
            end else if (w_tick) begin
              if (w_y_oob) begin
                // Vertical exit always freezes, even with bounce enabled
                r_within <= 1'b0;
                r_state  <= ST_OUT;
              end else if (w_x_oob) begin
`ifdef GAME_SPRITE_BOUNCE_EN
                r_x <= w_nx[X_WIDTH] ? {X_WIDTH{1'b0}} : L_MAX_X;
                r_y <= w_ny[Y_WIDTH-1:0];
                if (!sprite_write_dxy) begin
                  r_dx <= -r_dx;
                end
`else
                r_within <= 1'b0;
                r_state  <= ST_OUT;
`endif
              end else begin
                r_x <= w_nx[X_WIDTH-1:0];
                r_y <= w_ny[Y_WIDTH-1:0];
              end
            end
          end
          ST_OUT: begin
            r_state <= ST_OUT;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sprite_x             = r_x;
  assign sprite_y             = r_y;
  assign sprite_within_screen = r_within;

endmodule : game_sprite_motion

// File: tb/tb_game_sprite_motion.sv
// -----------------------------------------------------------------------------
// tb_game_sprite_motion
// Directed scenarios followed by randomized strobes, all checked against a
// behavioural model that counts enabled cycles since the last restart and
// applies the sprite motion rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_game_sprite_motion;

  localparam int PERIOD = 4;
  localparam int MAX_X  = 640 - 8;
  localparam int MAX_Y  = 480 - 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sprite_write_xy = 1'b0;
  logic [9:0] sprite_write_x = 10'd0;
  logic [9:0] sprite_write_y = 10'd0;
  logic       sprite_write_dxy = 1'b0;
  logic [3:0] sprite_write_dx = 4'd0;
  logic [3:0] sprite_write_dy = 4'd0;
  logic       sprite_enable_update = 1'b0;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       sprite_within_screen;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_x, m_y, m_dx, m_dy, m_run;
  bit m_in, m_out;

  game_sprite_motion dut (
    .clk                  (clk),
    .reset                (reset),
    .sprite_write_xy      (sprite_write_xy),
    .sprite_write_x       (sprite_write_x),
    .sprite_write_y       (sprite_write_y),
    .sprite_write_dxy     (sprite_write_dxy),
    .sprite_write_dx      (sprite_write_dx),
    .sprite_write_dy      (sprite_write_dy),
    .sprite_enable_update (sprite_enable_update),
    .sprite_x             (sprite_x),
    .sprite_y             (sprite_y),
    .sprite_within_screen (sprite_within_screen)
  );

  always #5 clk = ~clk;

  function automatic int wrap4(input int v);
    logic signed [3:0] t;
    t = v[3:0];
    return int'(t);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_run = 0;
    m_in = 1'b1; m_out = 1'b0;
  endtask

  // Apply one clock edge of the sprite rules to the model
  task automatic model_edge();
    int  nx, ny, wx, wy;
    bit  tick, neg_dx;
    nx = m_x + m_dx;
    ny = m_y + m_dy;
    tick = 1'b0;
    neg_dx = 1'b0;
    if (sprite_write_xy) begin
      wx = int'(sprite_write_x);
      wy = int'(sprite_write_y);
      m_x = wx; m_y = wy;
      m_in  = (wx <= MAX_X) && (wy <= MAX_Y);
      m_out = !m_in;
      m_run = 0;
    end else if (!m_out) begin
      if (!sprite_enable_update) m_run = 0;
      else begin
        m_run++;
        if (m_run == PERIOD) begin
          m_run = 0;
          tick = 1'b1;
        end
      end
    end
    if (tick) begin
      if (ny < 0 || ny > MAX_Y) begin
        m_in = 1'b0; m_out = 1'b1;
      end else if (nx < 0 || nx > MAX_X) begin
`ifdef GAME_SPRITE_BOUNCE_EN
        m_x = (nx < 0) ? 0 : MAX_X;
        m_y = ny;
        neg_dx = 1'b1;
`else
        m_in = 1'b0; m_out = 1'b1;
`endif
      end else begin
        m_x = nx; m_y = ny;
      end
    end
    if (sprite_write_dxy) begin
      m_dx = wrap4(int'(sprite_write_dx));
      m_dy = wrap4(int'(sprite_write_dy));
    end else if (neg_dx) begin
      m_dx = wrap4(-m_dx);
    end
  endtask

  // Advance n cycles, clearing strobes and checking outputs on each falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      sprite_write_xy  = 1'b0;
      sprite_write_dxy = 1'b0;
      check("x", int'(sprite_x), m_x);
      check("y", int'(sprite_y), m_y);
      check("within", int'(sprite_within_screen), int'(m_in));
    end
  endtask

  task automatic load_xy(input int x, input int y);
    sprite_write_xy = 1'b1;
    sprite_write_x  = 10'(x);
    sprite_write_y  = 10'(y);
  endtask

  task automatic load_dxy(input int dx, input int dy);
    sprite_write_dxy = 1'b1;
    sprite_write_dx  = 4'(dx);
    sprite_write_dy  = 4'(dy);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_x", int'(sprite_x), 0);
    check("rst_y", int'(sprite_y), 0);
    check("rst_within", int'(sprite_within_screen), 1);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);

    // Load position and velocity, then enable motion
    load_xy(100, 50);
    load_dxy(2, -1);
    cyc(1);
    sprite_enable_update = 1'b1;
    cyc(3);
    check("load_hold_x", int'(sprite_x), 100);
    cyc(1);
    check("step1_x", int'(sprite_x), 102);
    check("step1_y", int'(sprite_y), 49);
    cyc(4);
    check("step2_x", int'(sprite_x), 104);
    check("step2_y", int'(sprite_y), 48);
    check("step2_within", int'(sprite_within_screen), 1);

    // Right-edge exit and recovery via a position load
    sprite_enable_update = 1'b0;
    load_xy(630, 100);
    load_dxy(3, 0);
    cyc(1);
    sprite_enable_update = 1'b1;
    cyc(4);
    check("exit_x", int'(sprite_x), 630);
    check("exit_within", int'(sprite_within_screen), 0);
    cyc(8);
    check("frozen_x", int'(sprite_x), 630);
    load_xy(10, 100);
    cyc(1);
    check("reload_within", int'(sprite_within_screen), 1);
    cyc(4);
    check("resume_x", int'(sprite_x), 13);

    // Enable gating: drop enable one cycle before a step, then re-raise
    cyc(3);
    sprite_enable_update = 1'b0;
    cyc(2);
    sprite_enable_update = 1'b1;
    cyc(3);
    check("gate_hold_x", int'(sprite_x), 13);
    cyc(1);
    check("gate_step_x", int'(sprite_x), 16);

    // Write collisions with a tick
    cyc(3);
    load_xy(200, 100);
    load_dxy(1, 0);
    cyc(1);
    check("xy_vs_tick_x", int'(sprite_x), 200);
    cyc(3);
    load_dxy(-4, 0);
    cyc(1);
    check("dxy_vs_tick_x", int'(sprite_x), 201);
    cyc(4);
    check("new_dx_x", int'(sprite_x), 197);

    // Asynchronous reset during motion
    load_xy(300, 100);
    cyc(2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_x", int'(sprite_x), 0);
    check("arst_y", int'(sprite_y), 0);
    check("arst_within", int'(sprite_within_screen), 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    load_dxy(1, 0);
    cyc(3);
    check("post_rst_hold_x", int'(sprite_x), 0);
    cyc(1);
    check("post_rst_step_x", int'(sprite_x), 1);

    // Left-edge step: bounce or freeze depending on the build
    sprite_enable_update = 1'b0;
    load_xy(2, 100);
    load_dxy(-3, 0);
    cyc(1);
    sprite_enable_update = 1'b1;
    cyc(4);
`ifdef GAME_SPRITE_BOUNCE_EN
    check("bounce_x", int'(sprite_x), 0);
    check("bounce_within", int'(sprite_within_screen), 1);
    cyc(4);
    check("bounce_next_x", int'(sprite_x), 3);
`else
    check("left_exit_x", int'(sprite_x), 2);
    check("left_exit_within", int'(sprite_within_screen), 0);
`endif

    // Randomized strobes and enable
    for (int i = 0; i < 3000; i++) begin
      sprite_enable_update = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0)
        load_xy(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
      if ($urandom_range(0, 14) == 0)
        load_dxy(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_game_sprite_motion
